visstream: RTL and testbench

Downstream stage of the visibility block: captures the daisy-chained, per-frame visibility stream (real/imag pairs, no back-pressure) into a ping-pong buffer, then replays each complete frame as a back-pressured AXI4-Stream of packed 32-bit words. Frames that are short or long, or that would overwrite an unread bank, are discarded and counted, never partially emitted.

---
 rtl/visstream.sv | 225 ++++++++++++++++++++++
 tb/tb_visstream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/visstream.sv
// Ping-pong capture of a per-frame visibility stream, replayed as a back-pressured
// AXI4-Stream of {sext16(imag), sext16(real)} words; bad or overflowing frames are dropped.
module visstream #(
   parameter int WIDTH = 11,
   parameter int COUNT = 15
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             vis_frame_i,
   input  logic             vis_valid_i,
   input  logic             vis_last_i,
   input  logic [WIDTH-1:0] vis_rdata_i,
   input  logic [WIDTH-1:0] vis_idata_i,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic [31:0]      m_tdata,
   output logic [7:0]       drops_o,
   output logic             err_o
);
   localparam int ABITS = $clog2(COUNT);
   localparam logic [ABITS-1:0] LAST_ADDR = (ABITS)'(COUNT - 1);
   localparam logic [ABITS:0]   END_ADDR  = (ABITS + 1)'(COUNT);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_e;
   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_e;
   typedef enum logic [1:0] {R_IDLE, R_PREF, R_SEND} rstate_e;

   function automatic logic [15:0] sext16(input logic [WIDTH-1:0] v);
      sext16 = 16'($signed(v));
   endfunction

   bank_e                bank_st_r [2];
   logic                 wbank_r, rbank_r;
   wstate_e              ws_r, ws_next_s;
   logic [ABITS-1:0]     waddr_r, waddr_next_s, wr_addr_s;
   logic                 wr_en_s, fill_start_s, fill_done_s, fill_abort_s, drop_s, wbank_free_s;
   rstate_e              rs_r, rs_next_s;
   logic [ABITS:0]       raddr_r;
   logic [ABITS-1:0]     rd_addr_s, out_idx_r, next_idx_s;
   logic                 rd_en_s, take_s, rel_s, load_s;
   logic [2*WIDTH-1:0]   mem_r [2][COUNT];
   logic [2*WIDTH-1:0]   rd_data_r;

   // A bank released by the final handshake is reusable by a frame starting the same cycle
   assign wbank_free_s = (bank_st_r[wbank_r] == B_EMPTY) || (rel_s && (rbank_r == wbank_r));

   // Write FSM next-state: accept, fill, or discard the incoming frame
   always_comb begin
      ws_next_s    = ws_r;
      waddr_next_s = waddr_r;
      wr_en_s      = 1'b0;
      wr_addr_s    = waddr_r;
      fill_start_s = 1'b0;
      fill_done_s  = 1'b0;
      fill_abort_s = 1'b0;
      drop_s       = 1'b0;
      case (ws_r)
         W_IDLE: begin
            if (vis_valid_i && vis_frame_i) begin
               if (wbank_free_s && !vis_last_i) begin
                  wr_en_s      = 1'b1;
                  wr_addr_s    = '0;
                  waddr_next_s = (ABITS)'(1);
                  fill_start_s = 1'b1;
                  ws_next_s    = W_FILL;
               end else begin
                  drop_s    = 1'b1;
                  ws_next_s = vis_last_i ? W_IDLE : W_DROP;
               end
            end else begin
               ws_next_s = W_IDLE;
            end
         end
         W_FILL: begin
            if (vis_valid_i) begin
               if (vis_frame_i) begin
                  fill_abort_s = 1'b1;
                  drop_s       = 1'b1;
                  ws_next_s    = vis_last_i ? W_IDLE : W_DROP;
               end else if (vis_last_i) begin
                  if (waddr_r == LAST_ADDR) begin
                     wr_en_s     = 1'b1;
                     fill_done_s = 1'b1;
                  end else begin
                     fill_abort_s = 1'b1;
                     drop_s       = 1'b1;
                  end
                  ws_next_s = W_IDLE;
               end else if (waddr_r == LAST_ADDR) begin
                  // Bank is full but no last: the frame is too long
                  fill_abort_s = 1'b1;
                  drop_s       = 1'b1;
                  ws_next_s    = W_DROP;
               end else begin
                  wr_en_s      = 1'b1;
                  waddr_next_s = waddr_r + (ABITS)'(1);
               end
            end else begin
               ws_next_s = W_FILL;
            end
         end
         W_DROP: begin
            if (vis_valid_i && vis_last_i) begin
               ws_next_s = W_IDLE;
            end else begin
               ws_next_s = W_DROP;
            end
         end
         default: ws_next_s = W_IDLE;
      endcase
   end

   // Write FSM state, fill address and drop accounting
   always_ff @(posedge clock) begin
      if (!reset) begin
         ws_r    <= W_IDLE;
         waddr_r <= '0;
         err_o   <= 1'b0;
         drops_o <= 8'd0;
      end else begin
         ws_r    <= ws_next_s;
         waddr_r <= waddr_next_s;
         err_o   <= drop_s;
         if (drop_s && (drops_o != 8'hFF)) begin
            drops_o <= drops_o + 8'd1;
         end
      end
   end

   // Bank ownership; write-side updates are ordered last so a same-cycle reuse wins
   always_ff @(posedge clock) begin
      if (!reset) begin
         bank_st_r[0] <= B_EMPTY;
         bank_st_r[1] <= B_EMPTY;
         wbank_r      <= 1'b0;
         rbank_r      <= 1'b0;
      end else begin
         if (take_s) bank_st_r[rbank_r] <= B_READING;
         if (rel_s) begin
            bank_st_r[rbank_r] <= B_EMPTY;
            rbank_r            <= ~rbank_r;
         end
         if (fill_start_s) bank_st_r[wbank_r] <= B_FILLING;
         if (fill_done_s) begin
            bank_st_r[wbank_r] <= B_FULL;
            wbank_r            <= ~wbank_r;
         end
         if (fill_abort_s) bank_st_r[wbank_r] <= B_EMPTY;
      end
   end

   // Storage write port and registered read port
   always_ff @(posedge clock) begin
      if (wr_en_s) mem_r[wbank_r][wr_addr_s] <= {vis_idata_i, vis_rdata_i};
      if (rd_en_s) rd_data_r <= mem_r[rbank_r][rd_addr_s];
   end

   // Read FSM next-state: start a bank, prefetch, then advance one word per handshake
   always_comb begin
      rs_next_s  = rs_r;
      take_s     = 1'b0;
      rel_s      = 1'b0;
      load_s     = 1'b0;
      rd_en_s    = 1'b0;
      rd_addr_s  = raddr_r[ABITS-1:0];
      next_idx_s = out_idx_r + (ABITS)'(1);
      case (rs_r)
         R_IDLE: begin
            if (bank_st_r[rbank_r] == B_FULL) begin
               take_s    = 1'b1;
               rd_en_s   = 1'b1;
               rd_addr_s = '0;
               rs_next_s = R_PREF;
            end else begin
               rs_next_s = R_IDLE;
            end
         end
         R_PREF: begin
            load_s     = 1'b1;
            next_idx_s = '0;
            rd_en_s    = (raddr_r < END_ADDR);
            rs_next_s  = R_SEND;
         end
         R_SEND: begin
            if (m_tvalid && m_tready) begin
               if (m_tlast) begin
                  rel_s     = 1'b1;
                  rs_next_s = R_IDLE;
               end else begin
                  load_s  = 1'b1;
                  rd_en_s = (raddr_r < END_ADDR);
               end
            end else begin
               rs_next_s = R_SEND;
            end
         end
         default: rs_next_s = R_IDLE;
      endcase
   end

   // Read FSM state, prefetch address and AXI-S output register
   always_ff @(posedge clock) begin
      if (!reset) begin
         rs_r      <= R_IDLE;
         raddr_r   <= '0;
         out_idx_r <= '0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
         m_tdata   <= 32'd0;
      end else begin
         rs_r <= rs_next_s;
         if (rd_en_s) raddr_r <= {1'b0, rd_addr_s} + (ABITS + 1)'(1);
         if (load_s) begin
            m_tdata   <= {sext16(rd_data_r[2*WIDTH-1:WIDTH]), sext16(rd_data_r[WIDTH-1:0])};
            m_tvalid  <= 1'b1;
            m_tlast   <= (next_idx_s == LAST_ADDR);
            out_idx_r <= next_idx_s;
         end else if (rel_s) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_visstream.sv
// Directed bench for visstream: table-driven first frame plus hand-written
// overflow, length-error, random-ready, bank-release and reset sequences.
module tb_visstream;
   localparam int W = 11;
   localparam int C = 15;

   typedef struct {
      logic [W-1:0] re;
      logic [W-1:0] im;
      logic [31:0]  exp;
   } vec_t;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         vis_frame_i = 1'b0, vis_valid_i = 1'b0, vis_last_i = 1'b0;
   logic [W-1:0] vis_rdata_i = '0, vis_idata_i = '0;
   logic         m_tvalid, m_tready, m_tlast, err_o;
   logic [31:0]  m_tdata;
   logic [7:0]   drops_o;

   logic fixed_ready = 1'b0, rand_en = 1'b0, rnd_bit = 1'b0;
   assign m_tready = rand_en ? rnd_bit : fixed_ready;

   int n_cmp = 0, n_bad = 0, err_pulses = 0, n_last = 0;
   logic [32:0] cap_q [$];
   logic [32:0] exp_q [$];
   logic pv = 1'b0, pr = 1'b0, pl = 1'b0, pres = 1'b0;
   logic [31:0] pd = 32'd0;
   vec_t tbl [C];

   visstream #(.WIDTH(W), .COUNT(C)) dut (
      .clock(clock), .reset(reset), .vis_frame_i(vis_frame_i), .vis_valid_i(vis_valid_i),
      .vis_last_i(vis_last_i), .vis_rdata_i(vis_rdata_i), .vis_idata_i(vis_idata_i),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
      .drops_o(drops_o), .err_o(err_o));

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Capture handshakes, count error pulses and check stall stability
   always @(negedge clock) begin
      if (pres && pv && !pr) begin
         chk("hold_valid", 64'(m_tvalid), 64'd1);
         chk("hold_data", 64'(m_tdata), 64'(pd));
         chk("hold_last", 64'(m_tlast), 64'(pl));
      end
      if (m_tvalid && m_tready) begin
         cap_q.push_back({m_tlast, m_tdata});
         if (m_tlast) n_last <= n_last + 1;
      end
      if (err_o) err_pulses <= err_pulses + 1;
      pv <= m_tvalid; pr <= m_tready; pd <= m_tdata; pl <= m_tlast; pres <= reset;
   end

   // Random ready source
   initial forever begin
      @(posedge clock); #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int gen_r(input int seed, input int k);
      if (k == 3) return -1024;
      return ((seed * 37 + k * 13) % 2048) - 1024;
   endfunction

   function automatic int gen_i(input int seed, input int k);
      if (k == 3) return 1023;
      return ((seed * 91 + k * 7 + 5) % 2048) - 1024;
   endfunction

   function automatic logic [31:0] exp_word(input int r, input int i);
      return {i[15:0], r[15:0]};
   endfunction

   task automatic send_frame(input int seed, input int n, input int last_at, input bit good);
      int r, i;
      for (int k = 0; k < n; k++) begin
         @(posedge clock); #1;
         r = gen_r(seed, k);
         i = gen_i(seed, k);
         vis_valid_i = 1'b1;
         vis_frame_i = (k == 0);
         vis_last_i  = (k == last_at);
         vis_rdata_i = r[W-1:0];
         vis_idata_i = i[W-1:0];
         if (good) exp_q.push_back({(k == C - 1), exp_word(r, i)});
      end
   endtask

   task automatic idle(input int n);
      @(posedge clock); #1;
      vis_valid_i = 1'b0; vis_frame_i = 1'b0; vis_last_i = 1'b0;
      repeat (n) @(posedge clock);
   endtask

   task automatic check_stream(input string name, input int budget);
      int t = 0;
      int n;
      while (cap_q.size() < exp_q.size() && t < budget) begin
         @(posedge clock);
         t++;
      end
      repeat (5) @(posedge clock);
      #1;
      chk($sformatf("%s_count", name), 64'(cap_q.size()), 64'(exp_q.size()));
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int k = 0; k < n; k++)
         chk($sformatf("%s_w%0d", name, k), 64'(cap_q[k]), 64'(exp_q[k]));
      cap_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   initial begin
      int e0, l0, t;
      logic [31:0] exp_tab [C];
      exp_tab = '{32'h0000_0000, 32'hFFFF_0001, 32'hFFFE_0002, 32'hFFFD_0003, 32'hFFFC_0004,
                  32'hFFFB_0005, 32'hFFFA_0006, 32'hFFF9_0007, 32'hFFF8_0008, 32'hFFF7_0009,
                  32'hFFF6_000A, 32'hFFF5_000B, 32'hFFF4_000C, 32'hFFF3_000D, 32'hFFF2_000E};
      for (int k = 0; k < C; k++) begin
         tbl[k].re  = W'(k);
         tbl[k].im  = W'(-k);
         tbl[k].exp = exp_tab[k];
      end

      // Reset values
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      chk("rst_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_tlast", 64'(m_tlast), 64'd0);
      chk("rst_tdata", 64'(m_tdata), 64'd0);
      chk("rst_drops", 64'(drops_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);

      // Table frame: k / -k, ready held high, latency and throughput
      fixed_ready = 1'b1;
      for (int k = 0; k < C; k++) begin
         @(posedge clock); #1;
         vis_valid_i = 1'b1; vis_frame_i = (k == 0); vis_last_i = (k == C - 1);
         vis_rdata_i = tbl[k].re; vis_idata_i = tbl[k].im;
      end
      @(posedge clock); #1;
      vis_valid_i = 1'b0; vis_frame_i = 1'b0; vis_last_i = 1'b0;
      chk("lat_e0", 64'(m_tvalid), 64'd0);
      @(posedge clock); #1;
      chk("lat_e1", 64'(m_tvalid), 64'd0);
      @(posedge clock); #1;
      chk("lat_e2", 64'(m_tvalid), 64'd1);
      repeat (15) @(posedge clock);
      #1;
      chk("tbl_count", 64'(cap_q.size()), 64'd15);
      chk("tbl_done_valid", 64'(m_tvalid), 64'd0);
      for (int k = 0; k < C; k++)
         if (k < cap_q.size())
            chk($sformatf("tbl_w%0d", k), 64'(cap_q[k]), 64'({(k == C - 1), tbl[k].exp}));
      chk("tbl_drops", 64'(drops_o), 64'd0);
      chk("tbl_err", 64'(err_pulses), 64'd0);
      cap_q.delete();

      // Three frames with ready low: third overflows
      fixed_ready = 1'b0;
      e0 = err_pulses;
      send_frame(1, C, C - 1, 1'b1);
      send_frame(2, C, C - 1, 1'b1);
      send_frame(3, C, C - 1, 1'b0);
      idle(10);
      #1;
      chk("ovf_drops", 64'(drops_o), 64'd1);
      chk("ovf_err", 64'(err_pulses - e0), 64'd1);
      chk("ovf_stalled", 64'(m_tvalid), 64'd1);
      chk("ovf_nocap", 64'(cap_q.size()), 64'd0);
      fixed_ready = 1'b1;
      check_stream("ovf", 200);

      // Short and long frames, each followed by a good frame
      e0 = err_pulses;
      send_frame(4, 10, 9, 1'b0);
      send_frame(5, C, C - 1, 1'b1);
      send_frame(6, 16, 15, 1'b0);
      send_frame(7, C, C - 1, 1'b1);
      idle(5);
      check_stream("len", 300);
      chk("len_drops", 64'(drops_o), 64'd3);
      chk("len_err", 64'(err_pulses - e0), 64'd2);

      // Random ready over 20 frames
      l0 = n_last;
      rand_en = 1'b1;
      for (int f = 0; f < 20; f++) begin
         send_frame(10 + f, C, C - 1, 1'b1);
         idle(40);
      end
      check_stream("rnd", 2000);
      rand_en = 1'b0;
      chk("rnd_tlast", 64'(n_last - l0), 64'd20);
      chk("rnd_drops", 64'(drops_o), 64'd3);

      // Bank 0 released on the same edge a new frame targets it
      do_reset();
      fixed_ready = 1'b0;
      send_frame(20, C, C - 1, 1'b1);
      send_frame(21, C, C - 1, 1'b1);
      idle(5);
      #1 fixed_ready = 1'b1;
      repeat (13) @(posedge clock);
      send_frame(22, C, C - 1, 1'b1);
      idle(5);
      t = 0;
      while (cap_q.size() < 3 * C && t < 300) begin
         @(posedge clock);
         t++;
      end
      #1;
      chk("bnd_drops", 64'(drops_o), 64'd0);
      chk("bnd_min_re", 64'(cap_q[2 * C + 3][15:0]), 64'h0000_FC00);
      chk("bnd_max_im", 64'(cap_q[2 * C + 3][31:16]), 64'h0000_03FF);
      check_stream("bnd", 50);

      // Reset pulse while word 7 is on the output
      fixed_ready = 1'b1;
      send_frame(30, C, C - 1, 1'b1);
      idle(0);
      t = 0;
      do begin
         @(posedge clock); #1;
         t++;
      end while (cap_q.size() < 7 && t < 100);
      chk("mid_reached", 64'(cap_q.size()), 64'd7);
      reset = 1'b0;
      fixed_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      chk("mid_tvalid", 64'(m_tvalid), 64'd0);
      chk("mid_tlast", 64'(m_tlast), 64'd0);
      chk("mid_tdata", 64'(m_tdata), 64'd0);
      chk("mid_drops", 64'(drops_o), 64'd0);
      chk("mid_err", 64'(err_o), 64'd0);
      cap_q.delete();
      exp_q.delete();
      fixed_ready = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      chk("mid_no_partial", 64'(cap_q.size()), 64'd0);
      send_frame(31, C, C - 1, 1'b1);
      idle(5);
      check_stream("post_rst", 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
